// File: rtl/hal_ctrl.sv
// Key-driven sequencer for the register-bank + ALU datapath: turns debounced
// key levels into single-cycle strobes, all on clk.
module hal_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_show,
    input  logic             key_exec,
    input  logic [3:0]       opcode,
    output logic             sel_addr_a,
    output logic             sel_imm,
    output logic             alu_en,
    output logic             rb_we,
    output logic             show,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHOW    = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
        WRITE   = 3'd4,
        RELEASE = 3'd5
    } state_t;

    logic       exec_q, show_q;
    logic [3:0] op_q;
    logic [3:0] lat_cnt;
    logic       press_exec, press_show;

    assign press_exec = key_exec & ~exec_q;
    assign press_show = key_show & ~show_q;

    // busy is high exactly in DECODE..WRITE, the window where the operand
    // selects must hold their decoded values.
    assign sel_addr_a = busy;
    assign sel_imm    = busy & (op_q[3] | (op_q[1] & (~op_q[0] | op_q[2])));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            exec_q   <= 1'b1;
            show_q   <= 1'b1;
            op_q     <= 4'd0;
            lat_cnt  <= 4'd0;
            alu_en   <= 1'b0;
            rb_we    <= 1'b0;
            show     <= 1'b0;
            busy     <= 1'b0;
            op_count <= '0;
        end else begin
            exec_q <= key_exec;
            show_q <= key_show;
            alu_en <= 1'b0;
            rb_we  <= 1'b0;
            show   <= 1'b0;
            busy   <= 1'b0;
            case (state)
                IDLE: begin
                    // exec wins over a simultaneous show press
                    if (press_exec) begin
                        state <= DECODE;
                        op_q  <= opcode;
                        busy  <= 1'b1;
                    end else if (press_show) begin
                        state <= SHOW;
                        show  <= 1'b1;
                    end
                end
                SHOW: begin
                    if (key_show) show  <= 1'b1;
                    else          state <= IDLE;
                end
                DECODE: begin
                    state   <= EXEC;
                    busy    <= 1'b1;
                    alu_en  <= 1'b1;
                    lat_cnt <= 4'(ALU_LAT - 1);
                end
                EXEC: begin
                    busy <= 1'b1;
                    if (lat_cnt == 4'd0) begin
                        state <= WRITE;
                        rb_we <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                        alu_en  <= 1'b1;
                    end
                end
                WRITE: begin
                    state    <= RELEASE;
                    op_count <= op_count + CNT_W'(1);
                end
                RELEASE: begin
                    if (!key_exec) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hal_ctrl.sv
// Directed bench for hal_ctrl: two instances (ALU_LAT=1/CNT_W=8 and
// ALU_LAT=3/CNT_W=2) driven by the same keys, checked cycle by cycle.
module tb_hal_ctrl;

    logic       clk = 1'b0;
    logic       rst, key_show, key_exec;
    logic [3:0] opcode;

    logic       sa_a, imm_a, alu_a, we_a, show_a, busy_a;
    logic [2:0] state_a;
    logic [7:0] cnt_a;
    logic       sa_b, imm_b, alu_b, we_b, show_b, busy_b;
    logic [2:0] state_b;
    logic [1:0] cnt_b;
    logic [5:0] outs_a, outs_b;

    int vecs = 0, errs = 0;
    int wes_a = 0, wes_b = 0;
    int snap_a, snap_b;
    logic [1:0] exp_cnt [5];

    always #5 clk = ~clk;

    assign outs_a = {sa_a, imm_a, alu_a, we_a, show_a, busy_a};
    assign outs_b = {sa_b, imm_b, alu_b, we_b, show_b, busy_b};

    hal_ctrl #(.ALU_LAT(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .key_show(key_show), .key_exec(key_exec), .opcode(opcode),
        .sel_addr_a(sa_a), .sel_imm(imm_a), .alu_en(alu_a), .rb_we(we_a),
        .show(show_a), .busy(busy_a), .state(state_a), .op_count(cnt_a));

    hal_ctrl #(.ALU_LAT(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .key_show(key_show), .key_exec(key_exec), .opcode(opcode),
        .sel_addr_a(sa_b), .sel_imm(imm_b), .alu_en(alu_b), .rb_we(we_b),
        .show(show_b), .busy(busy_b), .state(state_b), .op_count(cnt_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // every cycle passes through here, so rb_we pulses are counted exactly once
    task automatic tick();
        @(negedge clk);
        if (we_a) wes_a++;
        if (we_b) wes_b++;
    endtask

    initial begin
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
        rst = 1'b1; key_show = 1'b0; key_exec = 1'b0; opcode = 4'd0;
        repeat (2) tick();
        chk("rst_state", 32'(state_a), 32'd0);
        chk("rst_outs", 32'(outs_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        tick();

        // 1: opcode 0010, ALU_LAT=1 timing
        opcode = 4'b0010; key_exec = 1'b1;
        tick(); chk("t1_decode_st", 32'(state_a), 32'd2); chk("t1_decode", 32'(outs_a), 32'b110001);
        tick(); chk("t1_exec_st", 32'(state_a), 32'd3);   chk("t1_exec", 32'(outs_a), 32'b111001);
        tick(); chk("t1_write_st", 32'(state_a), 32'd4);  chk("t1_write", 32'(outs_a), 32'b110101);
        tick(); chk("t1_rel_st", 32'(state_a), 32'd5);    chk("t1_rel", 32'(outs_a), 32'd0);
        chk("t1_cnt", 32'(cnt_a), 32'd1);
        key_exec = 1'b0;
        tick(); chk("t1_idle", 32'(state_a), 32'd0);
        repeat (6) tick();
        chk("t1_we", 32'(wes_a), 32'd1);

        // 2: opcode 0001 uses reg B; long hold runs once
        opcode = 4'b0001; key_exec = 1'b1;
        tick(); chk("t2_decode", 32'(outs_a), 32'b100001);
        repeat (20) tick();
        chk("t2_hold_st", 32'(state_a), 32'd5);
        chk("t2_hold_we", 32'(wes_a), 32'd2);
        key_exec = 1'b0;
        repeat (3) tick();
        key_exec = 1'b1;
        repeat (6) tick();
        key_exec = 1'b0;
        repeat (6) tick();
        chk("t2_we", 32'(wes_a), 32'd3);
        chk("t2_cnt", 32'(cnt_a), 32'd3);

        // 3: simultaneous press -> exec; then show mode ignores exec
        key_show = 1'b1; key_exec = 1'b1;
        tick(); chk("t3_both_st", 32'(state_a), 32'd2); chk("t3_both", 32'(outs_a), 32'b100001);
        repeat (4) tick();
        chk("t3_noshow", 32'(show_a), 32'd0);
        key_show = 1'b0; key_exec = 1'b0;
        repeat (6) tick();
        chk("t3_we1", 32'(wes_a), 32'd4);
        key_show = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_show", 32'(outs_a), 32'b000010);
            chk("t3_show_st", 32'(state_b), 32'd1);
            if (i == 1) key_exec = 1'b1;
            if (i == 3) key_exec = 1'b0;
            if (i == 4) key_show = 1'b0;
        end
        tick(); chk("t3_show_end", 32'(state_a), 32'd0); chk("t3_show_off", 32'(outs_a), 32'd0);
        repeat (6) tick();
        chk("t3_we2", 32'(wes_a), 32'd4);
        chk("t3_we2_b", 32'(wes_b), 32'd4);

        // 4: ALU_LAT=3, opcode 1000, opcode changes mid-op
        opcode = 4'b1000; key_exec = 1'b1;
        tick(); chk("t4_decode", 32'(outs_b), 32'b110001);
        tick(); chk("t4_exec1", 32'(outs_b), 32'b111001);
        opcode = 4'b0001;
        tick(); chk("t4_exec2", 32'(outs_b), 32'b111001);
        tick(); chk("t4_exec3", 32'(outs_b), 32'b111001);
        tick(); chk("t4_write_st", 32'(state_b), 32'd4); chk("t4_write", 32'(outs_b), 32'b110101);
        tick(); chk("t4_rel", 32'(outs_b), 32'd0);
        key_exec = 1'b0;
        repeat (4) tick();
        chk("t4_we", 32'(wes_b), 32'd5);
        chk("t4_cnt_a", 32'(cnt_a), 32'd5);

        // 5: reset during EXEC, key held across reset release
        key_exec = 1'b1;
        tick(); tick();
        chk("t5_exec", 32'(state_b), 32'd3);
        snap_a = wes_a; snap_b = wes_b;
        rst = 1'b1;
        #1;
        chk("t5_abort_st", 32'(state_b), 32'd0);
        chk("t5_abort_outs", 32'(outs_b), 32'd0);
        chk("t5_abort_cnt", 32'(cnt_a), 32'd0);
        tick(); tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("t5_no_we_a", 32'(wes_a - snap_a), 32'd0);
        chk("t5_no_we_b", 32'(wes_b - snap_b), 32'd0);
        chk("t5_held_st", 32'(state_a), 32'd0);
        chk("t5_cnt_b", 32'(cnt_b), 32'd0);
        key_exec = 1'b0;
        repeat (2) tick();

        // 6: CNT_W=2 wrap, then illegal state recovery
        for (int i = 0; i < 5; i++) begin
            key_exec = 1'b1;
            repeat (7) tick();
            chk("t6_cnt", 32'(cnt_b), 32'(exp_cnt[i]));
            key_exec = 1'b0;
            repeat (2) tick();
        end
        chk("t6_cnt_a", 32'(cnt_a), 32'd5);
        force dut_b.state = 3'd7;
        #1;
        release dut_b.state;
        tick();
        chk("t6_illegal_st", 32'(state_b), 32'd0);
        chk("t6_illegal_outs", 32'(outs_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
